nios_system_sysid_regs: RTL

NIOS_SYSTEM_SYSID_REGS -- requirements
Module: nios_system_sysid_regs

---
 rtl/nios_system_sysid_regs.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/nios_system_sysid_regs.sv
`default_nettype none
// ============================================================================
// Module      : nios_system_sysid_regs
// Description : Avalon-MM system-ID slave. Returns a build-time system ID and
//               timestamp, plus 1..3 byte-writable scratch words. With the
//               SYSID_UPTIME_EN macro defined it also has a free-running 64-bit
//               uptime counter, a latched high-word shadow and a CONTROL word
//               (bit0 CLEAR, write-1 self-clearing; bit1 FREEZE).
//               Read latency is a fixed single cycle and the slave never stalls.
//
// Word map    : 0 SYSTEM_ID, 1 TIMESTAMP, 2 UPTIME_LO, 3 UPTIME_HI shadow,
//               4 CONTROL, 5..4+NUM_SCRATCH scratch. Other words read 0.
//
// Ports       : clock          - single clock, rising edge
//               reset_n        - synchronous, active-low reset
//               address        - word address [ADDR_W-1:0]
//               read / write   - one-cycle transfer strobes
//               writedata      - 32-bit write data
//               byteenable     - per-byte write enables
//               readdata       - registered read data, 0 when not valid
//               readdatavalid  - qualifies readdata
//
// Parameters  : SYSTEM_ID, TIMESTAMP (32-bit constants), NUM_SCRATCH (1..3),
//               ADDR_W (>= 3)
// Revision    : 1.0 - initial release
// ============================================================================
module nios_system_sysid_regs #(
    parameter logic [31:0] SYSTEM_ID   = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP   = 32'h0000_0000,
    parameter int          NUM_SCRATCH = 2,
    parameter int          ADDR_W      = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam logic [ADDR_W-1:0] c_ADDR_SYSID = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] c_ADDR_TSTMP = ADDR_W'(1);
    localparam int                c_SCRATCH_BASE = 5;

    // A simultaneous read and write performs only the write.
    logic rd_fire;
    assign rd_fire = read & ~write;

    // ------------------------------------------------------------------
    // Scratch words
    // ------------------------------------------------------------------
    logic [31:0] scratch_q [NUM_SCRATCH];
    logic [31:0] scratch_d [NUM_SCRATCH];

    always_comb begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            scratch_d[i] = scratch_q[i];
            if (write && (address == ADDR_W'(c_SCRATCH_BASE + i))) begin
                for (int b = 0; b < 4; b++) begin
                    if (byteenable[b]) begin
                        scratch_d[i][8*b +: 8] = writedata[8*b +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (!reset_n) begin
                scratch_q[i] <= 32'h0;
            end else begin
                scratch_q[i] <= scratch_d[i];
            end
        end
    end

`ifdef SYSID_UPTIME_EN
    // ------------------------------------------------------------------
    // Uptime counter, high-word shadow and CONTROL
    // ------------------------------------------------------------------
    localparam logic [ADDR_W-1:0] c_ADDR_UPLO = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] c_ADDR_UPHI = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] c_ADDR_CTRL = ADDR_W'(4);

    logic [63:0] uptime_q, uptime_d;
    logic [31:0] shadow_q, shadow_d;
    logic        freeze_q, freeze_d;
    logic        ctrl_wr;
    logic        clear;

    // CONTROL only lives in byte lane 0.
    assign ctrl_wr = write && (address == c_ADDR_CTRL) && byteenable[0];
    assign clear   = ctrl_wr && writedata[0];

    always_comb begin
        freeze_d = ctrl_wr ? writedata[1] : freeze_q;
        // CLEAR wins over FREEZE so a combined write leaves the counter at 0.
        if (clear) begin
            uptime_d = 64'h0;
        end else if (freeze_q) begin
            uptime_d = uptime_q;
        end else begin
            uptime_d = uptime_q + 64'h1;
        end
        // Latching the high half on a LO read gives a coherent 64-bit pair.
        shadow_d = (rd_fire && (address == c_ADDR_UPLO)) ? uptime_q[63:32] : shadow_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            uptime_q <= 64'h0;
            shadow_q <= 32'h0;
            freeze_q <= 1'b0;
        end else begin
            uptime_q <= uptime_d;
            shadow_q <= shadow_d;
            freeze_q <= freeze_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [31:0] rdata_mux;

    always_comb begin
        rdata_mux = 32'h0;
        if (address == c_ADDR_SYSID) begin
            rdata_mux = SYSTEM_ID;
        end
        if (address == c_ADDR_TSTMP) begin
            rdata_mux = TIMESTAMP;
        end
`ifdef SYSID_UPTIME_EN
        if (address == c_ADDR_UPLO) begin
            rdata_mux = uptime_q[31:0];
        end
        if (address == c_ADDR_UPHI) begin
            rdata_mux = shadow_q;
        end
        if (address == c_ADDR_CTRL) begin
            rdata_mux = {30'h0, freeze_q, 1'b0};
        end
`endif
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (address == ADDR_W'(c_SCRATCH_BASE + i)) begin
                rdata_mux = scratch_q[i];
            end
        end
    end

    logic [31:0] readdata_q, readdata_d;
    logic        rdv_q, rdv_d;

    always_comb begin
        rdv_d      = rd_fire;
        readdata_d = rd_fire ? rdata_mux : 32'h0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata_q <= 32'h0;
            rdv_q      <= 1'b0;
        end else begin
            readdata_q <= readdata_d;
            rdv_q      <= rdv_d;
        end
    end

    // Reset arriving during a data cycle must kill that cycle immediately,
    // so the registered outputs are gated by reset_n.
    assign readdatavalid = rdv_q & reset_n;
    assign readdata      = readdata_q & {32{reset_n}};

endmodule
`default_nettype wire
